// File: rtl/mem_responder_if.sv
// CPU-to-memory command bus: one command per cycle, fixed one-cycle read latency.
interface mem_responder_if;
   logic [1:0]  mem_cmd;
   logic [8:0]  mem_addr;
   logic [15:0] write_data;
   logic [15:0] read_data;

   modport master (
      output mem_cmd,
      output mem_addr,
      output write_data,
      input  read_data
   );

   modport slave (
      input  mem_cmd,
      input  mem_addr,
      input  write_data,
      output read_data
   );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: word RAM in the lower half of the address space,
// LED / switch / cycle-counter registers in the upper half.
// Read data is registered (one-cycle latency); bus_err is sticky until reset.
module mem_responder #(
   parameter int unsigned RAM_WORDS = 256,
   parameter logic [8:0]  LED_ADDR  = 9'h100,
   parameter logic [8:0]  SW_ADDR   = 9'h140,
   parameter logic [8:0]  CNT_ADDR  = 9'h141
) (
   input  logic                  clk,
   input  logic                  reset,
   mem_responder_if.slave        bus,
   input  logic [7:0]            SW,
   output logic [7:0]            LEDR,
   output logic                  bus_err
);

   typedef enum logic [1:0] {
      CMD_NONE    = 2'b00,
      CMD_MREAD   = 2'b01,
      CMD_MWRITE  = 2'b10,
      CMD_ILLEGAL = 2'b11
   } cmd_e;

   cmd_e        cmd;
   logic        ram_sel;
   logic        led_sel;
   logic        sw_sel;
   logic        cnt_sel;
   logic [7:0]  ram_idx;

   logic [15:0] ram [RAM_WORDS];
   logic [15:0] read_q;
   logic [15:0] cnt_q;
   logic [7:0]  led_q;
   logic [7:0]  sw_meta;
   logic [7:0]  sw_sync;
   logic        err_q;

   // Command and address decode.
   always_comb begin
      cmd     = cmd_e'(bus.mem_cmd);
      ram_idx = bus.mem_addr[7:0];
      ram_sel = !bus.mem_addr[8] && ({1'b0, bus.mem_addr[7:0]} < 9'(RAM_WORDS));
      led_sel = (bus.mem_addr == LED_ADDR);
      sw_sel  = (bus.mem_addr == SW_ADDR);
      cnt_sel = (bus.mem_addr == CNT_ADDR);
   end

   // RAM write port; contents are deliberately not touched by reset.
   always_ff @(posedge clk) begin
      if (!reset && (cmd == CMD_MWRITE) && ram_sel) begin
         ram[ram_idx] <= bus.write_data;
      end
   end

   // Switch synchronizer and free-running cycle counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         sw_meta <= '0;
         sw_sync <= '0;
         cnt_q   <= '0;
      end else begin
         sw_meta <= SW;
         sw_sync <= sw_meta;
         cnt_q   <= cnt_q + 16'd1;
      end
   end

   // Command execution: read data register, LED register and sticky error.
   always_ff @(posedge clk) begin
      if (reset) begin
         read_q <= '0;
         led_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         case (cmd)
            CMD_NONE: ;
            CMD_MREAD: begin
               if (ram_sel) begin
                  read_q <= ram[ram_idx];
               end else if (led_sel) begin
                  read_q <= {8'h00, led_q};
               end else if (sw_sel) begin
                  read_q <= {8'h00, sw_sync};
               end else if (cnt_sel) begin
                  read_q <= cnt_q;
               end else begin
                  read_q <= '0;
                  err_q  <= 1'b1;
               end
            end
            CMD_MWRITE: begin
               // RAM writes are handled by the RAM port; anything else but LED is an error.
               if (led_sel) begin
                  led_q <= bus.write_data[7:0];
               end else if (!ram_sel) begin
                  err_q <= 1'b1;
               end
            end
            CMD_ILLEGAL: err_q <= 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.read_data = read_q;
   assign LEDR          = led_q;
   assign bus_err       = err_q;

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU's `mem_cmd` / `mem_addr` bus. It sits between the CPU and the on-chip RAM and board I/O, and serves the CPU's MREAD and MWRITE commands:
- Lower half of the 9-bit address space: word RAM.
- Upper half: memory-mapped LEDs, switches and a free-running cycle counter.

Read data is registered with one-cycle latency, which matches the CPU's IF1→IF2 and load-state timing.

## Interface
Parameters:
- `RAM_WORDS`, 256, RAM depth in 16-bit words; occupies addresses 0x000–0x0FF.
- `LED_ADDR`, 9'h100, read/write LED register.
- `SW_ADDR`, 9'h140, read-only switch input.
- `CNT_ADDR`, 9'h141, read-only cycle counter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_cmd`  in  2  command: 2'b00 none, 2'b01 MREAD, 2'b10 MWRITE, 2'b11 illegal.
- `mem_addr`  in  9  word address.
- `write_data`  in  16  store data; the CPU's datapath output.
- `read_data`  out  16  registered read data; the CPU's `in`.
- `SW`  in  8  asynchronous board switches.
- `LEDR`  out  8  LED register.
- `bus_err`  out  1  sticky error flag.

## Operation
- Address decode:
  - `mem_addr[8]==0` selects RAM word `mem_addr[7:0]`.
  - `mem_addr[8]==1` selects I/O: LED_ADDR, SW_ADDR or CNT_ADDR. Any other I/O address is unmapped.
- MWRITE:
  - RAM target: `write_data` is written to RAM at the edge.
  - LED_ADDR: `LEDR <= write_data[7:0]`.
  - SW_ADDR, CNT_ADDR or unmapped: write discarded, `bus_err` set.
  - `read_data` holds its value.
- MREAD: `read_data` is loaded at the edge with:
  - RAM target: the RAM word.
  - LED_ADDR: `{8'h00, LEDR}`.
  - SW_ADDR: `{8'h00, sw_sync}`.
  - CNT_ADDR: the counter value before its increment at that edge.
  - Unmapped: 16'h0000, and `bus_err` is set.
- No command (2'b00): no state change except the synchronizer and the counter; `read_data` holds.
- Illegal command (2'b11): no access; `bus_err` set; `read_data` holds.
- Switch synchronizer: two flops, `SW` → `sw_meta` → `sw_sync`.
- Counter: 16-bit, +1 every cycle outside reset, wraps 16'hFFFF → 16'h0000.
- `bus_err`: sticky; cleared only by reset.
- RAM: not cleared by reset; contents persist across reset. Simulation may preload RAM from a hex file.

## Timing
- Reset values:
  - `read_data` = 16'h0000, `LEDR` = 8'h00, `bus_err` = 0.
  - Counter = 0; `sw_meta` and `sw_sync` = 0.
- Reset priority: reset overrides any command in the same cycle. A write presented during reset is discarded and does not set `bus_err`.
- Read latency: address and MREAD sampled at edge N; `read_data` valid from just after edge N until the next MREAD edge.
- Write latency: written at edge N. An MREAD of the same address at edge N+1 returns the new value (no bypass needed; the accesses are in different cycles).
- Command rate: one command per cycle; back-to-back reads and writes are supported at full rate with no stall.
- Switch latency: a change on `SW` appears in a read issued ≥2 edges later.
- Fixed-latency slave: there is no handshake or ready signal. The CPU holds `mem_cmd`/`mem_addr` for one cycle per access and samples `read_data` in the following cycle.
- Reset mid-operation: a read issued at the reset edge returns nothing; `read_data` = 0 after the reset edge.

## Test plan
- Reset with `LEDR` = 8'hFF and `bus_err` = 1 → both cleared, `read_data` = 0; a RAM word written earlier still reads back its old value.
- MWRITE 0x005 ← 16'hABCD, then MREAD 0x005 on the next cycle → `read_data` = 16'hABCD one edge later. Then MREAD 0x0FF with a preloaded 16'h1234 → 16'h1234.
- MWRITE LED_ADDR ← 16'h00A5 → `LEDR` = 8'hA5. MREAD LED_ADDR → 16'h00A5.
- `SW` = 8'h3C applied; MREAD SW_ADDR 1 edge later → 16'h0000; 2 edges later → 16'h003C.
- Two MREADs of CNT_ADDR 5 cycles apart → values differ by exactly 5. Hold 65536 cycles → value wraps back to its starting value.
- MWRITE SW_ADDR, MREAD 0x1F0, and `mem_cmd` = 2'b11 each set `bus_err` = 1 with RAM and `LEDR` unchanged; MREAD 0x1F0 returns 16'h0000.
